// File: rtl/keyvalue_cmd_bridge.sv
// Byte-stream command front-end for the pin-side key-value store port.
// Parses put/get commands, runs one STB/ACK bus cycle each, and streams back status/data.
module keyvalue_cmd_bridge #(
    parameter int unsigned TIMEOUT = 256,
    parameter logic [7:0]  OP_PUT  = 8'h50,
    parameter logic [7:0]  OP_GET  = 8'h47
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       STB_o,
    output logic       WE_o,
    output logic [7:0] ADR_o,
    output logic [7:0] DAT_o,
    input  logic [7:0] DAT_i,
    input  logic       ACK_i
);

    localparam int unsigned     CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_VAL,
        S_BUS,
        S_RSP0,
        S_RSP1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_data_q;
    logic          stb_q;
    logic          we_q;
    logic          get_q;
    logic [7:0]    adr_q;
    logic [7:0]    dat_q;
    logic [7:0]    rdata_q;

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign STB_o     = stb_q;
    assign WE_o      = we_q;
    assign ADR_o     = adr_q;
    assign DAT_o     = dat_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            get_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rdata_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        if (cmd_data == OP_PUT) begin
                            we_q    <= 1'b1;
                            get_q   <= 1'b0;
                            state_q <= S_KEY;
                        end else if (cmd_data == OP_GET) begin
                            we_q    <= 1'b0;
                            get_q   <= 1'b1;
                            state_q <= S_KEY;
                        end else begin
                            // Unknown opcode: single-byte error reply, bus untouched.
                            get_q       <= 1'b0;
                            rsp_data_q  <= 8'hEE;
                            rsp_valid_q <= 1'b1;
                            cmd_ready_q <= 1'b0;
                            state_q     <= S_RSP0;
                        end
                    end
                end
                S_KEY: begin
                    if (cmd_valid && cmd_ready_q) begin
                        adr_q <= cmd_data;
                        if (we_q) begin
                            state_q <= S_VAL;
                        end else begin
                            cmd_ready_q <= 1'b0;
                            stb_q       <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= S_BUS;
                        end
                    end
                end
                S_VAL: begin
                    if (cmd_valid && cmd_ready_q) begin
                        dat_q       <= cmd_data;
                        cmd_ready_q <= 1'b0;
                        stb_q       <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_BUS;
                    end
                end
                S_BUS: begin
                    cnt_q <= cnt_q + 1'b1;
                    // ACK is tested first so it wins over a coincident timeout.
                    if (ACK_i) begin
                        if (!we_q) begin
                            rdata_q <= DAT_i;
                        end
                        rsp_data_q  <= 8'h00;
                        rsp_valid_q <= 1'b1;
                        stb_q       <= 1'b0;
                        state_q     <= S_RSP0;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q     <= 8'h00;
                        rsp_data_q  <= 8'hFF;
                        rsp_valid_q <= 1'b1;
                        stb_q       <= 1'b0;
                        state_q     <= S_RSP0;
                    end
                end
                S_RSP0: begin
                    if (rsp_ready) begin
                        if (get_q) begin
                            rsp_data_q <= rdata_q;
                            state_q    <= S_RSP1;
                        end else begin
                            rsp_valid_q <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                S_RSP1: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keyvalue_cmd_bridge.sv
// Directed bench for keyvalue_cmd_bridge: put, get, timeout, bad opcode,
// response backpressure and mid-operation reset, with hand-computed expectations.
module tb_keyvalue_cmd_bridge;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       STB_o;
    logic       WE_o;
    logic [7:0] ADR_o;
    logic [7:0] DAT_o;
    logic [7:0] DAT_i;
    logic       ACK_i;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    keyvalue_cmd_bridge #(
        .TIMEOUT(16),
        .OP_PUT (8'h50),
        .OP_GET (8'h47)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cmd_data (cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .rsp_data (rsp_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .STB_o    (STB_o),
        .WE_o     (WE_o),
        .ADR_o    (ADR_o),
        .DAT_o    (DAT_o),
        .DAT_i    (DAT_i),
        .ACK_i    (ACK_i)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input string tag);
        int n = 0;
        @(negedge sys_clk);
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        if (!cmd_ready) begin
            chk_cnt++;
            $display("FAIL %s_accept: cmd_ready=0 after %0d cycles, required 1", tag, n);
            cmd_valid = 1'b0;
        end else begin
            @(posedge sys_clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic recv_byte(output logic [7:0] b, input string tag);
        int n = 0;
        @(negedge sys_clk);
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        if (!rsp_valid) begin
            chk_cnt++;
            $display("FAIL %s_rsp_wait: rsp_valid=0 after %0d cycles, required 1", tag, n);
            b = 8'hxx;
            rsp_ready = 1'b0;
        end else begin
            b = rsp_data;
            @(posedge sys_clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic pulse_ack(input logic [7:0] d);
        ACK_i = 1'b1;
        DAT_i = d;
        @(posedge sys_clk);
        #1 ACK_i = 1'b0;
        DAT_i = 8'h00;
    endtask

    task automatic do_put(input logic [7:0] k, input logic [7:0] v, input string tag);
        logic [7:0] b;
        send_byte(8'h50, tag);
        send_byte(k, tag);
        send_byte(v, tag);
        @(negedge sys_clk);
        chk_cnt++;
        if ({STB_o, WE_o, ADR_o, DAT_o} !== {1'b1, 1'b1, k, v})
            $display("FAIL %s_bus: STB/WE/ADR/DAT=%b/%b/%h/%h required 1/1/%h/%h", tag, STB_o, WE_o, ADR_o, DAT_o, k, v);
        else pass_cnt++;
        pulse_ack(8'hC3);
        recv_byte(b, tag);
        chk_cnt++;
        if (b !== 8'h00) $display("FAIL %s_status: got %h required 00", tag, b);
        else pass_cnt++;
        @(negedge sys_clk);
        chk_cnt++;
        if ({cmd_ready, rsp_valid} !== 2'b10)
            $display("FAIL %s_idle: cmd_ready/rsp_valid=%b/%b required 1/0", tag, cmd_ready, rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk_cnt++;
        if ({cmd_ready, rsp_valid, STB_o, WE_o} !== 4'b0000)
            $display("FAIL reset_ctrl: cmd_ready/rsp_valid/STB/WE=%b%b%b%b required 0000", cmd_ready, rsp_valid, STB_o, WE_o);
        else pass_cnt++;
        chk_cnt++;
        if ({ADR_o, DAT_o, rsp_data} !== 24'h000000)
            $display("FAIL reset_data: ADR/DAT/rsp_data=%h/%h/%h required 00/00/00", ADR_o, DAT_o, rsp_data);
        else pass_cnt++;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_put();
        int n_hi = 0;
        logic [7:0] b;
        send_byte(8'h50, "put");
        send_byte(8'h12, "put");
        send_byte(8'h34, "put");
        for (int c = 1; c <= 3; c++) begin
            @(negedge sys_clk);
            if (STB_o) n_hi++;
            if (c == 1) begin
                chk_cnt++;
                if ({WE_o, ADR_o, DAT_o} !== {1'b1, 8'h12, 8'h34})
                    $display("FAIL put_bus: WE/ADR/DAT=%b/%h/%h required 1/12/34", WE_o, ADR_o, DAT_o);
                else pass_cnt++;
            end
            if (c == 3) ACK_i = 1'b1;
        end
        @(posedge sys_clk);
        #1 ACK_i = 1'b0;
        @(negedge sys_clk);
        chk_cnt++;
        if (n_hi != 3 || STB_o !== 1'b0)
            $display("FAIL put_stb_len: high %0d cycles then STB=%b, required 3 then 0", n_hi, STB_o);
        else pass_cnt++;
        chk_cnt++;
        if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 8'h00, 1'b0})
            $display("FAIL put_rsp: rsp_valid/rsp_data/cmd_ready=%b/%h/%b required 1/00/0", rsp_valid, rsp_data, cmd_ready);
        else pass_cnt++;
        recv_byte(b, "put");
        chk_cnt++;
        if (b !== 8'h00) $display("FAIL put_status: got %h required 00", b);
        else pass_cnt++;
        @(negedge sys_clk);
        chk_cnt++;
        if ({cmd_ready, rsp_valid} !== 2'b10)
            $display("FAIL put_idle: cmd_ready/rsp_valid=%b/%b required 1/0", cmd_ready, rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_get();
        logic [7:0] b;
        send_byte(8'h47, "get");
        send_byte(8'h12, "get");
        @(negedge sys_clk);
        chk_cnt++;
        if ({STB_o, WE_o, ADR_o} !== {1'b1, 1'b0, 8'h12})
            $display("FAIL get_bus: STB/WE/ADR=%b/%b/%h required 1/0/12", STB_o, WE_o, ADR_o);
        else pass_cnt++;
        pulse_ack(8'hAB);
        @(negedge sys_clk);
        chk_cnt++;
        if ({STB_o, rsp_valid, rsp_data} !== {1'b0, 1'b1, 8'h00})
            $display("FAIL get_after_ack: STB/rsp_valid/rsp_data=%b/%b/%h required 0/1/00", STB_o, rsp_valid, rsp_data);
        else pass_cnt++;
        recv_byte(b, "get");
        chk_cnt++;
        if (b !== 8'h00) $display("FAIL get_status: got %h required 00", b);
        else pass_cnt++;
        recv_byte(b, "get");
        chk_cnt++;
        if (b !== 8'hAB) $display("FAIL get_data: got %h required AB", b);
        else pass_cnt++;
        @(negedge sys_clk);
        chk_cnt++;
        if ({cmd_ready, rsp_valid} !== 2'b10)
            $display("FAIL get_idle: cmd_ready/rsp_valid=%b/%b required 1/0", cmd_ready, rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n = 0;
        logic [7:0] b;
        send_byte(8'h47, "tmo");
        send_byte(8'h05, "tmo");
        @(negedge sys_clk);
        chk_cnt++;
        if ({STB_o, ADR_o} !== {1'b1, 8'h05})
            $display("FAIL tmo_bus: STB/ADR=%b/%h required 1/05", STB_o, ADR_o);
        else pass_cnt++;
        while (STB_o && n < 40) begin
            n++;
            @(negedge sys_clk);
        end
        chk_cnt++;
        if (n != 16) $display("FAIL tmo_stb_len: STB high %0d cycles, required 16", n);
        else pass_cnt++;
        chk_cnt++;
        if ({rsp_valid, rsp_data} !== {1'b1, 8'hFF})
            $display("FAIL tmo_rsp: rsp_valid/rsp_data=%b/%h required 1/FF", rsp_valid, rsp_data);
        else pass_cnt++;
        pulse_ack(8'h77);
        @(negedge sys_clk);
        chk_cnt++;
        if ({STB_o, rsp_valid, rsp_data} !== {1'b0, 1'b1, 8'hFF})
            $display("FAIL tmo_late_ack: STB/rsp_valid/rsp_data=%b/%b/%h required 0/1/FF", STB_o, rsp_valid, rsp_data);
        else pass_cnt++;
        recv_byte(b, "tmo");
        chk_cnt++;
        if (b !== 8'hFF) $display("FAIL tmo_status: got %h required FF", b);
        else pass_cnt++;
        recv_byte(b, "tmo");
        chk_cnt++;
        if (b !== 8'h00) $display("FAIL tmo_data: got %h required 00", b);
        else pass_cnt++;
        @(negedge sys_clk);
        pulse_ack(8'h77);
        @(negedge sys_clk);
        chk_cnt++;
        if ({STB_o, rsp_valid, cmd_ready} !== 3'b001)
            $display("FAIL tmo_idle_ack: STB/rsp_valid/cmd_ready=%b/%b/%b required 0/0/1", STB_o, rsp_valid, cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_bad_opcode();
        logic [7:0] b;
        send_byte(8'h99, "bad");
        @(negedge sys_clk);
        chk_cnt++;
        if ({STB_o, rsp_valid, rsp_data} !== {1'b0, 1'b1, 8'hEE})
            $display("FAIL bad_rsp: STB/rsp_valid/rsp_data=%b/%b/%h required 0/1/EE", STB_o, rsp_valid, rsp_data);
        else pass_cnt++;
        recv_byte(b, "bad");
        chk_cnt++;
        if (b !== 8'hEE) $display("FAIL bad_status: got %h required EE", b);
        else pass_cnt++;
        @(negedge sys_clk);
        chk_cnt++;
        if ({STB_o, rsp_valid, cmd_ready} !== 3'b001)
            $display("FAIL bad_single: STB/rsp_valid/cmd_ready=%b/%b/%b required 0/0/1", STB_o, rsp_valid, cmd_ready);
        else pass_cnt++;
        do_put(8'hA5, 8'h3C, "bad_next");
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        send_byte(8'h47, "bp");
        send_byte(8'h33, "bp");
        @(negedge sys_clk);
        pulse_ack(8'h5A);
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            chk_cnt++;
            if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 8'h00, 1'b0})
                $display("FAIL bp_hold%0d: rsp_valid/rsp_data/cmd_ready=%b/%h/%b required 1/00/0", c, rsp_valid, rsp_data, cmd_ready);
            else pass_cnt++;
        end
        recv_byte(b, "bp");
        chk_cnt++;
        if (b !== 8'h00) $display("FAIL bp_status: got %h required 00", b);
        else pass_cnt++;
        @(negedge sys_clk);
        chk_cnt++;
        if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 8'h5A, 1'b0})
            $display("FAIL bp_second: rsp_valid/rsp_data/cmd_ready=%b/%h/%b required 1/5A/0", rsp_valid, rsp_data, cmd_ready);
        else pass_cnt++;
        recv_byte(b, "bp");
        chk_cnt++;
        if (b !== 8'h5A) $display("FAIL bp_data: got %h required 5A", b);
        else pass_cnt++;
        @(negedge sys_clk);
        chk_cnt++;
        if ({cmd_ready, rsp_valid} !== 2'b10)
            $display("FAIL bp_idle: cmd_ready/rsp_valid=%b/%b required 1/0", cmd_ready, rsp_valid);
        else pass_cnt++;
    endtask

    task automatic reset_pulse_check(input string tag);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk_cnt++;
        if ({STB_o, rsp_valid, cmd_ready, rsp_data} !== {3'b000, 8'h00})
            $display("FAIL %s_forced: STB/rsp_valid/cmd_ready/rsp_data=%b/%b/%b/%h required 0/0/0/00", tag, STB_o, rsp_valid, cmd_ready, rsp_data);
        else pass_cnt++;
        @(negedge sys_clk);
        chk_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL %s_ready: cmd_ready=%b required 1", tag, cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        send_byte(8'h50, "rbus");
        send_byte(8'h01, "rbus");
        send_byte(8'h02, "rbus");
        @(negedge sys_clk);
        chk_cnt++;
        if (STB_o !== 1'b1) $display("FAIL rbus_stb: STB=%b required 1", STB_o);
        else pass_cnt++;
        reset_pulse_check("rbus");
        do_put(8'h77, 8'h88, "rbus_put");

        send_byte(8'h47, "rrsp");
        send_byte(8'h44, "rrsp");
        @(negedge sys_clk);
        pulse_ack(8'h99);
        recv_byte(b, "rrsp");
        chk_cnt++;
        if (b !== 8'h00) $display("FAIL rrsp_status: got %h required 00", b);
        else pass_cnt++;
        @(negedge sys_clk);
        chk_cnt++;
        if ({rsp_valid, rsp_data} !== {1'b1, 8'h99})
            $display("FAIL rrsp_in_rsp1: rsp_valid/rsp_data=%b/%h required 1/99", rsp_valid, rsp_data);
        else pass_cnt++;
        reset_pulse_check("rrsp");
        do_put(8'h10, 8'h20, "rrsp_put");
    endtask

    initial begin
        sys_rst   = 1'b1;
        cmd_data  = 8'h00;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        DAT_i     = 8'h00;
        ACK_i     = 1'b0;
        test_reset();
        test_put();
        test_get();
        test_timeout();
        test_bad_opcode();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
